// File: rtl/uart_word_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : link_pkg
// Purpose  : Shared types and helpers for the UART word framing layer.
//            byte_sel() is the single definition of the on-wire byte order
//            and is used by both the transmit and receive directions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package link_pkg;

  localparam int BYTE_W = 8;

  // Default application word type.
  typedef logic signed [15:0] num;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SEND  = 2'd1,
    TX_GAP   = 2'd2,
    TX_DRAIN = 2'd3
  } tx_state_e;

  function automatic int bytes_per_word(input int word_w);
    return word_w / BYTE_W;
  endfunction

  // Flat bit offset of byte byte_idx (0 = first on the wire) of word word_idx.
  function automatic int byte_sel(input int word_idx, input int byte_idx,
                                  input int b, input int msb_first);
    int lane;
    lane = (msb_first != 0) ? (b - 1 - byte_idx) : byte_idx;
    return (word_idx * b + lane) * BYTE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_framer
// Purpose  : Assembles RX_WORDS words from the deserialiser byte stream and
//            presents them with a valid/ack handshake, sticky overrun flag,
//            resync input and inter-byte timeout.
// Ports    : clk, reset        - clock, async active-high reset
//            des_data/des_valid - incoming byte and its strobe
//            rx_sync            - restart framing (discard partial frame)
//            rx_ack             - consumer has taken rx_words
//            rx_valid/rx_words  - completed frame
//            rx_overrun         - sticky, frame dropped while rx_valid=1
//            rx_timeout         - one-cycle pulse on partial-frame discard
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_framer
  import link_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int RX_WORDS    = 25,
  parameter int MSB_FIRST   = 0,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 des_data,
  input  logic                       des_valid,
  input  logic                       rx_sync,
  input  logic                       rx_ack,
  output logic                       rx_valid,
  output logic [RX_WORDS*WORD_W-1:0] rx_words,
  output logic                       rx_overrun,
  output logic                       rx_timeout
);

  localparam int   B        = bytes_per_word(WORD_W);
  localparam int   RX_BYTES = RX_WORDS * B;
  localparam int   CW       = $clog2(RX_BYTES + 1);
  localparam int   IW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic TO_EN    = (TIMEOUT_CYC > 0);

  logic [CW-1:0]                count_q, count_d;
  logic [IW-1:0]                idle_q, idle_d;
  logic [RX_WORDS*WORD_W-1:0]   part_q, part_d;
  logic [RX_WORDS*WORD_W-1:0]   words_q, words_d;
  logic                         valid_q, valid_d;
  logic                         ovr_q, ovr_d;
  logic                         tout_q, tout_d;

  logic [CW-1:0]                base;
  logic                         done;
  logic                         ack_take;

  always_comb begin
    count_d  = count_q;
    idle_d   = idle_q;
    part_d   = part_q;
    words_d  = words_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    tout_d   = 1'b0;
    done     = 1'b0;
    ack_take = rx_ack & valid_q;

    // A byte arriving together with rx_sync becomes byte 0 of the new frame.
    base = rx_sync ? '0 : count_q;

    if (des_valid) begin
      for (int k = 0; k < RX_BYTES; k++) begin
        if (base == CW'(k)) begin
          part_d[byte_sel(k / B, k % B, B, MSB_FIRST) +: BYTE_W] = des_data;
        end
      end
      if (base == CW'(RX_BYTES - 1)) begin
        done    = 1'b1;
        count_d = '0;
      end else begin
        count_d = base + CW'(1);
      end
      idle_d = '0;
    end else if (rx_sync) begin
      count_d = '0;
      idle_d  = '0;
    end else if (TO_EN && (count_q != '0)) begin
      if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
        count_d = '0;
        idle_d  = '0;
        tout_d  = 1'b1;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end else begin
      idle_d = '0;
    end

    // part_d already contains the final byte, so the frame commits directly.
    if (done) begin
      if (!valid_q || ack_take) begin
        words_d = part_d;
        valid_d = 1'b1;
        if (ack_take) begin
          ovr_d = 1'b0;
        end
      end else begin
        ovr_d = 1'b1;
      end
    end else if (ack_take) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      idle_q  <= '0;
      part_q  <= '0;
      words_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      idle_q  <= idle_d;
      part_q  <= part_d;
      words_q <= words_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      tout_q  <= tout_d;
    end
  end

  assign rx_valid   = valid_q;
  assign rx_words   = words_q;
  assign rx_overrun = ovr_q;
  assign rx_timeout = tout_q;

endmodule
`default_nettype wire

// File: rtl/uart_word_link.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_link
// Purpose  : Word-level framing between the application datapath and a
//            byte UART serialiser/deserialiser. Transmits TX_WORDS words as
//            a byte stream and assembles RX_WORDS words from received bytes.
// Ports    : clk, reset           - clock, async active-high reset
//            tx_start/tx_words    - frame request and words to send
//            tx_ready             - idle and able to accept tx_start
//            ser_data/ser_start   - byte and launch strobe to serialiser
//            ser_ready            - serialiser idle
//            des_data/des_valid   - byte from deserialiser
//            rx_sync, rx_ack      - resync and consumer acknowledge
//            rx_valid, rx_words   - received frame
//            rx_overrun           - sticky dropped-frame flag
//            rx_timeout           - partial-frame discard pulse
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_link
  import link_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int TX_WORDS    = 1,
  parameter int RX_WORDS    = 25,
  parameter int MSB_FIRST   = 0,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_start,
  input  logic [TX_WORDS*WORD_W-1:0] tx_words,
  output logic                       tx_ready,
  output logic [7:0]                 ser_data,
  output logic                       ser_start,
  input  logic                       ser_ready,
  input  logic [7:0]                 des_data,
  input  logic                       des_valid,
  input  logic                       rx_sync,
  output logic                       rx_valid,
  input  logic                       rx_ack,
  output logic [RX_WORDS*WORD_W-1:0] rx_words,
  output logic                       rx_overrun,
  output logic                       rx_timeout
);

  localparam int B        = bytes_per_word(WORD_W);
  localparam int TX_BYTES = TX_WORDS * B;
  localparam int TXIW     = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;

  tx_state_e                  state_q, state_d;
  logic [TXIW-1:0]            idx_q, idx_d;
  logic [TX_WORDS*WORD_W-1:0] buf_q, buf_d;
  logic [7:0]                 ser_data_q, ser_data_d;
  logic                       ser_start_q, ser_start_d;
  logic                       load_byte;

  // ser_start is registered: it is raised on the transition into SEND, when
  // ser_ready has just been seen high and nothing else can start the
  // serialiser in between.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    ser_data_d  = ser_data_q;
    ser_start_d = 1'b0;
    tx_ready    = 1'b0;
    load_byte   = 1'b0;

    case (state_q)
      TX_IDLE: begin
        tx_ready = ser_ready;
        if (tx_start && ser_ready) begin
          buf_d       = tx_words;
          idx_d       = '0;
          load_byte   = 1'b1;
          ser_start_d = 1'b1;
          state_d     = TX_SEND;
        end
      end
      TX_SEND: begin
        if (ser_start_q) begin
          state_d = TX_GAP;
        end else begin
          ser_start_d = ser_ready;
        end
      end
      TX_GAP: begin
        state_d = TX_DRAIN;
      end
      TX_DRAIN: begin
        if (ser_ready) begin
          if (idx_q == TXIW'(TX_BYTES - 1)) begin
            state_d = TX_IDLE;
          end else begin
            idx_d       = idx_q + TXIW'(1);
            load_byte   = 1'b1;
            ser_start_d = 1'b1;
            state_d     = TX_SEND;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase

    if (load_byte) begin
      for (int k = 0; k < TX_BYTES; k++) begin
        if (idx_d == TXIW'(k)) begin
          ser_data_d = buf_d[byte_sel(k / B, k % B, B, MSB_FIRST) +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= TX_IDLE;
      idx_q       <= '0;
      buf_q       <= '0;
      ser_data_q  <= '0;
      ser_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      ser_data_q  <= ser_data_d;
      ser_start_q <= ser_start_d;
    end
  end

  assign ser_data  = ser_data_q;
  assign ser_start = ser_start_q;

  uart_rx_framer #(
    .WORD_W      (WORD_W),
    .RX_WORDS    (RX_WORDS),
    .MSB_FIRST   (MSB_FIRST),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx_framer (
    .clk        (clk),
    .reset      (reset),
    .des_data   (des_data),
    .des_valid  (des_valid),
    .rx_sync    (rx_sync),
    .rx_ack     (rx_ack),
    .rx_valid   (rx_valid),
    .rx_words   (rx_words),
    .rx_overrun (rx_overrun),
    .rx_timeout (rx_timeout)
  );

endmodule
`default_nettype wire
